qracc_csr_bank: RTL and testbench
=================================

Name: qracc_csr_bank

Overview:
Parametrised control/status register bank for the QR accelerator. Sits between the peripheral request/response port and the accelerator core. Replaces the single fixed register file with:
- N configurable config registers
- a registered, back-pressurable response channel
- sticky W1C status with interrupt
- self-clearing start/clear pulses
- write-lock of config while the core is busy

Parameters:
CSR_WIDTH, 32, data width of every register and the bus
NUM_CSR, 8, total register count (address 0..NUM_CSR-1), minimum 3
ADDR_WIDTH, $clog2(NUM_CSR)+1, request address width; one extra bit so the optional counter and out-of-range addresses are expressible

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  bank can accept a request
req_wen  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  register index
req_wdata  in  CSR_WIDTH  write data
req_wstrb  in  CSR_WIDTH/8  byte write enables
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  CSR_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  request rejected
cfg_o  out  (NUM_CSR-2)*CSR_WIDTH  config registers 2..NUM_CSR-1, flattened; reg 2 in LSBs
start_o  out  1  one-cycle start pulse to core
clear_o  out  1  one-cycle clear pulse to core
busy_i  in  1  core busy level
done_i  in  1  core done pulse
irq_o  out  1  interrupt, level

Behaviour:
- Reset is nrst, asynchronous, active-low; clock is clk. On reset every register is 0, the FSM is in IDLE, and every output is 0 except req_ready=1.
- Register map:
  - 0 CTRL: bit0 START (write-1 pulses start_o, reads 0); bit1 CLEAR (write-1 pulses clear_o, reads 0); bit2 IRQ_EN (RW). Other bits read 0.
  - 1 STATUS: bit0 BUSY (RO, equals busy_i); bit1 DONE (sticky, W1C); bit2 ERR (sticky, W1C). Other bits read 0.
  - 2..NUM_CSR-1 CONFIG: RW with byte strobes.
- FSM has two states:
  - IDLE: req_ready=1. On req_valid, perform the access and go to RESP next cycle.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata/rsp_err are held stable until rsp_ready; on rsp_ready return to IDLE.
  - One request outstanding at a time; the next accept is the cycle after the response handshake at the earliest.
- Latency: accept in cycle N gives rsp_valid in cycle N+1.
- Write effects (register update, start_o/clear_o pulse) occur in cycle N+1, with exactly one pulse per accepted write.
- Read data is sampled at accept, so a concurrent DONE set appears on the next read.
- Errors set rsp_err=1 and STATUS.ERR; nothing is written:
  - address >= NUM_CSR (other than the enabled counter address);
  - write to a CONFIG register while busy_i=1;
  - START written while busy_i=1 (no start_o pulse is emitted).
- A W1C write to STATUS clears the written bits. If done_i is asserted in the same cycle as the W1C of DONE, set wins and DONE stays 1.
- CLEAR also clears DONE and ERR. CLEAR does not touch CONFIG.
- START=1 and CLEAR=1 in the same write: clear_o pulses; start_o pulses one cycle later.
- irq_o = IRQ_EN & (DONE | ERR), registered: one cycle after a flag sets.
- Zero strobes: the write is accepted and rsp_err=0, but no register changes.
- Reset mid-transaction: the response is dropped and the FSM returns to IDLE.

Optional Feature:
- Macro: QRACC_CSR_PERF_COUNTER_EN.
- Defined:
  - Address NUM_CSR is a RO 32-bit busy-cycle counter.
  - Increments every cycle busy_i=1 and saturates at all-ones.
  - Resets to 0 on the start_o pulse and on clear_o.
  - A write to it returns rsp_err=1.
- Undefined: address NUM_CSR behaves as out-of-range (rsp_err=1, ERR set).

Test Plan:
- Write addr 2 data 0xDEADBEEF, wstrb 4'b0101, then read -> rdata 0x00AD00EF; cfg_o[31:0]=0x00AD00EF; rsp_valid exactly 1 cycle after accept.
- Write CTRL 0x5 with busy_i=0 -> start_o high for exactly one cycle, IRQ_EN=1. Then pulse done_i -> STATUS reads 0x2 with busy low; irq_o=1 next cycle. Write STATUS 0x2 -> irq_o=0.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rdata stable, req_ready=0; second request is not accepted until rsp_ready=1.
- busy_i=1, write addr 3 0x1234 -> rsp_err=1, reg 3 unchanged, STATUS.ERR=1. Write CTRL 0x1 -> no start_o, rsp_err=1.
- done_i pulse coincident with a W1C write of 0x2 to STATUS -> DONE still reads 1. Read address NUM_CSR+1 -> rsp_err=1, rdata 0.
- With QRACC_CSR_PERF_COUNTER_EN: start, then hold busy_i high for 10 cycles -> counter reads 10. Without it: the same read gives rsp_err=1.

Source files
------------

// File: rtl/qracc_csr_bank.sv
// Control/status register bank for the QR accelerator: CTRL, W1C STATUS, byte-strobed CONFIG, one-deep response.
// Define QRACC_CSR_PERF_COUNTER_EN to map a saturating busy-cycle counter at address NUM_CSR.
module qracc_csr_bank #(
    parameter int CSR_WIDTH  = 32,
    parameter int NUM_CSR    = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_CSR) + 1
) (
    input  logic                              clk,
    input  logic                              nrst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_wen,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [CSR_WIDTH-1:0]              req_wdata,
    input  logic [CSR_WIDTH/8-1:0]            req_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [CSR_WIDTH-1:0]              rsp_rdata,
    output logic                              rsp_err,
    output logic [(NUM_CSR-2)*CSR_WIDTH-1:0]  cfg_o,
    output logic                              start_o,
    output logic                              clear_o,
    input  logic                              busy_i,
    input  logic                              done_i,
    output logic                              irq_o
);
    localparam int NCFG  = NUM_CSR - 2;
    localparam int NSTRB = CSR_WIDTH / 8;

    typedef enum logic {IDLE, RESP} state_e;
    state_e state_q, state_d;

    logic [NCFG-1:0][CSR_WIDTH-1:0] cfg_q, cfg_d;
    logic [CSR_WIDTH-1:0] rdata_q, rdata_d;
    logic rerr_q, rerr_d;
    logic irq_en_q, irq_en_d;
    logic done_q, done_d, err_q, err_d;
    logic start_q, start_d, clear_q, clear_d, pend_q, pend_d;
    logic irq_q;

    logic is_ctrl, is_status, is_cfg, is_cnt, wr_start, wr_clear, bad;
    logic [CSR_WIDTH-1:0] rd_val, cnt_rd;

`ifdef QRACC_CSR_PERF_COUNTER_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                       cnt_q <= '0;
        else if (start_q || clear_q)     cnt_q <= '0;
        else if (busy_i && cnt_q != '1)  cnt_q <= cnt_q + 32'd1;
    end

    assign is_cnt = (req_addr == ADDR_WIDTH'(NUM_CSR));
    assign cnt_rd = CSR_WIDTH'(cnt_q);
`else
    assign is_cnt = 1'b0;
    assign cnt_rd = '0;
`endif

    always_comb begin
        is_ctrl   = (req_addr == '0);
        is_status = (req_addr == ADDR_WIDTH'(1));
        is_cfg    = 1'b0;
        rd_val    = '0;
        for (int unsigned i = 0; i < NCFG; i++) begin
            if (req_addr == ADDR_WIDTH'(i + 2)) begin
                is_cfg = 1'b1;
                rd_val = cfg_q[i];
            end
        end
        if (is_ctrl)   rd_val = CSR_WIDTH'({irq_en_q, 2'b00});
        if (is_status) rd_val = CSR_WIDTH'({err_q, done_q, busy_i});
        if (is_cnt)    rd_val = cnt_rd;
        wr_start = req_wen & is_ctrl & req_wstrb[0] & req_wdata[0];
        wr_clear = req_wen & is_ctrl & req_wstrb[0] & req_wdata[1];
        bad = ~(is_ctrl | is_status | is_cfg | is_cnt)
            | (req_wen & ((is_cfg & busy_i) | (wr_start & busy_i) | is_cnt));
    end

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        irq_en_d = irq_en_q;
        done_d   = done_q | done_i;
        err_d    = err_q;
        start_d  = pend_q;
        clear_d  = 1'b0;
        pend_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = RESP;
                    rerr_d  = bad;
                    rdata_d = (req_wen || bad) ? '0 : rd_val;
                    if (bad) begin
                        err_d = 1'b1;
                    end else if (req_wen) begin
                        if (is_ctrl && req_wstrb[0]) begin
                            irq_en_d = req_wdata[2];
                            clear_d  = wr_clear;
                            // START alongside CLEAR is deferred one cycle so the core sees clear first
                            start_d  = start_d | (wr_start & ~wr_clear);
                            pend_d   = wr_start & wr_clear;
                        end
                        if (is_status && req_wstrb[0]) begin
                            done_d = (done_q & ~req_wdata[1]) | done_i;
                            err_d  = err_q & ~req_wdata[2];
                        end
                        for (int unsigned i = 0; i < NCFG; i++) begin
                            if (req_addr == ADDR_WIDTH'(i + 2)) begin
                                for (int unsigned b = 0; b < NSTRB; b++) begin
                                    if (req_wstrb[b]) cfg_d[i][b*8 +: 8] = req_wdata[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_d) begin
            done_d = done_i;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
            clear_q  <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            start_q  <= start_d;
            clear_q  <= clear_d;
            pend_q   <= pend_d;
            irq_q    <= irq_en_q & (done_q | err_q);
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;
    assign cfg_o     = cfg_q;
    assign start_o   = start_q;
    assign clear_o   = clear_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_qracc_csr_bank.sv
// Randomized bench for qracc_csr_bank against a transaction-level register model.
module tb_qracc_csr_bank;
    localparam int CW = 32;
    localparam int NC = 8;
    localparam int AW = $clog2(NC) + 1;
    localparam int SW = CW / 8;
`ifdef QRACC_CSR_PERF_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic req_valid = 1'b0, req_wen = 1'b0, rsp_ready = 1'b0, busy_i = 1'b0, done_i = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [CW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic req_ready, rsp_valid, rsp_err, start_o, clear_o, irq_o;
    logic [CW-1:0] rsp_rdata;
    logic [(NC-2)*CW-1:0] cfg_o;

    qracc_csr_bank #(.CSR_WIDTH(CW), .NUM_CSR(NC), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cfg_o(cfg_o),
        .start_o(start_o), .clear_o(clear_o), .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, cnt_rst_cyc = -1;
    int start_n = 0, clear_n = 0, start_cyc = -1, clear_cyc = -1;

    // reference model
    logic [CW-1:0] cfg_m [NC];
    logic irq_en_m = 1'b0, done_m = 1'b0, err_m = 1'b0;
    logic [31:0] cnt_m = '0;
    logic [CW-1:0] last_rd;
    logic last_err;

    always @(posedge clk) begin
        cyc++;
        if (!nrst) cnt_m = '0;
        else if (cyc == cnt_rst_cyc) cnt_m = '0;
        else if (busy_i && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
    end

    always @(negedge clk) begin
        if (start_o) begin start_n++; start_cyc = cyc; end
        if (clear_o) begin clear_n++; clear_cyc = cyc; end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) cfg_m[i] = '0;
        irq_en_m = 1'b0; done_m = 1'b0; err_m = 1'b0;
    endtask

    function automatic logic [(NC-2)*CW-1:0] exp_cfg();
        logic [(NC-2)*CW-1:0] v;
        for (int i = 2; i < NC; i++) v[(i-2)*CW +: CW] = cfg_m[i];
        return v;
    endfunction

    task automatic xact(input logic wen, input logic [AW-1:0] addr, input logic [CW-1:0] wdata,
                        input logic [SW-1:0] wstrb, input int hold, input logic dn);
        int ai, s0, c0, acc;
        logic is_cfg, wr_start, wr_clear, exp_err, ok_s, ok_c;
        logic [CW-1:0] exp_rd;
        ai = int'(addr);
        is_cfg   = (ai >= 2 && ai < NC);
        wr_start = wen && ai == 0 && wstrb[0] && wdata[0];
        wr_clear = wen && ai == 0 && wstrb[0] && wdata[1];
        exp_err  = !(ai < NC || (CNT_EN && ai == NC));
        if (wen && ((is_cfg && busy_i) || (wr_start && busy_i) || (CNT_EN && ai == NC))) exp_err = 1'b1;
        exp_rd = '0;
        if (!wen && !exp_err) begin
            if (ai == 0)       exp_rd = irq_en_m ? CW'(4) : '0;
            else if (ai == 1)  exp_rd = CW'({err_m, done_m, busy_i});
            else if (ai == NC) exp_rd = CW'(cnt_m);
            else               exp_rd = cfg_m[ai];
        end
        ok_s = wr_start && !exp_err;
        ok_c = wr_clear && !exp_err;

        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; done_i = dn;
        chk("req_ready_idle", req_ready, 1'b1);
        s0 = start_n; c0 = clear_n;
        tick();
        acc = cyc;
        req_valid = 1'b0; done_i = 1'b0;
        if (ok_s || ok_c) cnt_rst_cyc = acc + 1;
        chk("rsp_valid_lat", rsp_valid, 1'b1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        last_rd = rsp_rdata; last_err = rsp_err;

        if (exp_err) err_m = 1'b1;
        else if (wen) begin
            if (ai == 0 && wstrb[0]) begin
                irq_en_m = wdata[2];
                if (wr_clear) begin done_m = 1'b0; err_m = 1'b0; end
            end
            if (ai == 1 && wstrb[0]) begin
                if (wdata[1]) done_m = 1'b0;
                if (wdata[2]) err_m = 1'b0;
            end
            if (is_cfg)
                for (int b = 0; b < SW; b++)
                    if (wstrb[b]) cfg_m[ai][b*8 +: 8] = wdata[b*8 +: 8];
        end
        if (dn) done_m = 1'b1;

        // a second request offered while the response is stalled must be ignored
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_wen = 1'b1; req_addr = AW'(2); req_wdata = $urandom; req_wstrb = '1;
            rsp_ready = 1'b0;
            tick();
            chk("hold_req_ready", req_ready, 1'b0);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", rsp_err, exp_err);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_req_ready", req_ready, 1'b1);
        tick();
        chk("start_pulses", start_n - s0, ok_s ? 1 : 0);
        chk("clear_pulses", clear_n - c0, ok_c ? 1 : 0);
        if (ok_c) chk("clear_time", clear_cyc, acc);
        if (ok_s) chk("start_time", start_cyc, ok_c ? acc + 1 : acc);
        chk("cfg_o", cfg_o, exp_cfg());
        chk("irq_o", irq_o, irq_en_m & (done_m | err_m));
    endtask

    task automatic done_pulse();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        done_m = 1'b1;
        tick();
        chk("irq_after_done", irq_o, irq_en_m & (done_m | err_m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic wen, dn;
        logic [AW-1:0] a;
        model_reset();
        tick(); tick();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, '0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_cfg", cfg_o, '0);
        chk("rst_pulses", {start_o, clear_o, irq_o}, 3'b000);
        nrst = 1'b1;
        tick();

        xact(1'b1, AW'(2), 32'hDEADBEEF, 4'b0101, 0, 1'b0);
        xact(1'b0, AW'(2), '0, '0, 0, 1'b0);
        chk("strobe_read", last_rd, 32'h00AD00EF);
        chk("strobe_cfg", cfg_o[31:0], 32'h00AD00EF);

        xact(1'b1, AW'(0), 32'h5, 4'hF, 0, 1'b0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        done_m = 1'b1;
        chk("irq_lag", irq_o, 1'b0);
        tick();
        chk("irq_set", irq_o, 1'b1);
        xact(1'b0, AW'(1), '0, '0, 0, 1'b0);
        chk("status_done", last_rd, 32'h2);
        xact(1'b1, AW'(1), 32'h2, 4'hF, 0, 1'b0);
        chk("irq_cleared", irq_o, 1'b0);

        xact(1'b0, AW'(2), '0, '0, 5, 1'b0);

        busy_i = 1'b1;
        xact(1'b1, AW'(3), 32'h1234, 4'hF, 0, 1'b0);
        chk("busy_cfg_err", last_err, 1'b1);
        xact(1'b1, AW'(0), 32'h1, 4'hF, 0, 1'b0);
        chk("busy_start_err", last_err, 1'b1);
        busy_i = 1'b0;
        xact(1'b1, AW'(0), 32'h7, 4'hF, 1, 1'b0);

        xact(1'b1, AW'(1), 32'h2, 4'hF, 0, 1'b1);
        xact(1'b0, AW'(1), '0, '0, 0, 1'b0);
        chk("done_set_wins", last_rd[1], 1'b1);
        xact(1'b0, AW'(NC + 1), '0, '0, 0, 1'b0);
        chk("oor_err", last_err, 1'b1);
        chk("oor_rdata", last_rd, '0);

        xact(1'b1, AW'(0), 32'h1, 4'hF, 0, 1'b0);
        busy_i = 1'b1;
        repeat (10) tick();
        busy_i = 1'b0;
        xact(1'b0, AW'(NC), '0, '0, 0, 1'b0);
`ifdef QRACC_CSR_PERF_COUNTER_EN
        chk("busy_count", last_rd, 32'd10);
`else
        chk("no_counter_err", last_err, 1'b1);
`endif

        for (int n = 0; n < 200; n++) begin
            busy_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                done_pulse();
            end else begin
                wen = 1'($urandom_range(0, 1));
                a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, NC + 1));
                dn = ($urandom_range(0, 9) == 0);
                xact(wen, a, $urandom, SW'($urandom), $urandom_range(0, 2), dn);
            end
        end
        busy_i = 1'b0;

        req_valid = 1'b1; req_wen = 1'b1; req_addr = AW'(4); req_wdata = 32'hA5A5A5A5; req_wstrb = '1;
        tick();
        req_valid = 1'b0;
        nrst = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_cfg", cfg_o, '0);
        chk("midrst_irq", irq_o, 1'b0);
        model_reset();
        tick();
        nrst = 1'b1;
        tick();
        xact(1'b0, AW'(4), '0, '0, 0, 1'b0);
        chk("midrst_read", last_rd, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
